// File: rtl/la_capture_engine.sv
// la_capture_engine: NUM_CH-lane sample capture into an external RAM ring with a programmable
// pre/post-trigger split, edge/pattern/force trigger and a handshaked per-channel readout.
module la_capture_engine #(
  parameter int NUM_CH  = 5,
  parameter int W       = 8,
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9,
  parameter int LOG2CH  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                abort,
  input  logic [1:0]          trig_mode,
  input  logic [LOG2CH-1:0]   trig_ch,
  input  logic [NUM_CH-1:0]   trig_mask,
  input  logic [NUM_CH-1:0]   trig_match,
  input  logic [LOG2-1:0]     trig_pos,
  input  logic                wrt_smpl,
  input  logic [NUM_CH*W-1:0] smpl_din,
  input  logic [NUM_CH-1:0]   trig_in,
  output logic                we,
  output logic [LOG2-1:0]     waddr,
  output logic [NUM_CH*W-1:0] wdata,
  output logic [LOG2-1:0]     raddr,
  input  logic [NUM_CH*W-1:0] rdata,
  input  logic                dump,
  input  logic [LOG2CH-1:0]   dump_ch,
  output logic [W-1:0]        out_data,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic                busy,
  output logic                triggered,
  output logic                done
);

  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE, RD, LAT, SEND} state_t;

  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);
  localparam logic [LOG2:0]   ENT  = (LOG2 + 1)'(ENTRIES);

  state_t              state;
  logic [LOG2-1:0]     wptr, pre_cnt, tpe, oldest, rd_ptr, rd_cnt;
  logic [LOG2:0]       post_cnt;
  logic [1:0]          mode;
  logic [LOG2CH-1:0]   tch, dch;
  logic [NUM_CH-1:0]   mask, match, prev;
  logic                prev_valid;

  logic [LOG2-1:0]     tpe_in, wptr_nxt, rd_ptr_nxt;
  logic [LOG2:0]       post_need;
  logic                cur_bit, prev_bit, ch_ok, fire, capturing;
  logic [W-1:0]        lane;

  always_comb begin
    tpe_in     = (trig_pos > LAST) ? LAST : trig_pos;
    wptr_nxt   = (wptr == LAST) ? '0 : wptr + LOG2'(1);
    rd_ptr_nxt = (rd_ptr == LAST) ? '0 : rd_ptr + LOG2'(1);
    post_need  = ENT - {1'b0, tpe};
    capturing  = (state == PRE) || (state == ARMED) || (state == POST);
    cur_bit    = 1'b0;
    prev_bit   = 1'b0;
    ch_ok      = 1'b0;
    lane       = '0;
    // Out-of-range channel selects leave ch_ok low / lane zero.
    for (int k = 0; k < NUM_CH; k++) begin
      if (tch == LOG2CH'(k)) begin
        cur_bit  = trig_in[k];
        prev_bit = prev[k];
        ch_ok    = 1'b1;
      end
      if (dch == LOG2CH'(k)) lane = rdata[k*W +: W];
    end
    fire = 1'b0;
    case (mode)
      2'b00:   fire = ch_ok & prev_valid & ~prev_bit & cur_bit;
      2'b01:   fire = ch_ok & prev_valid & prev_bit & ~cur_bit;
      2'b10:   fire = (((trig_in ^ match) & mask) == '0);
      default: fire = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      raddr      <= '0;
      out_data   <= '0;
      out_vld    <= 1'b0;
      busy       <= 1'b0;
      triggered  <= 1'b0;
      done       <= 1'b0;
      wptr       <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      tpe        <= '0;
      oldest     <= '0;
      rd_ptr     <= '0;
      rd_cnt     <= '0;
      mode       <= 2'b00;
      tch        <= '0;
      dch        <= '0;
      mask       <= '0;
      match      <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
    end else begin
      we <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        busy      <= 1'b0;
        done      <= 1'b0;
        triggered <= 1'b0;
        out_vld   <= 1'b0;
      end else if (arm && !(state inside {RD, LAT, SEND})) begin
        wptr       <= '0;
        waddr      <= '0;
        pre_cnt    <= '0;
        post_cnt   <= '0;
        triggered  <= 1'b0;
        prev_valid <= 1'b0;
        mode       <= trig_mode;
        tch        <= trig_ch;
        mask       <= trig_mask;
        match      <= trig_match;
        tpe        <= tpe_in;
        state      <= (tpe_in == '0) ? ARMED : PRE;
        busy       <= 1'b1;
        done       <= 1'b0;
      end else begin
        if (wrt_smpl && capturing) begin
          we         <= 1'b1;
          waddr      <= wptr;
          wdata      <= smpl_din;
          wptr       <= wptr_nxt;
          prev       <= trig_in;
          prev_valid <= 1'b1;
        end
        case (state)
          PRE: if (wrt_smpl) begin
            pre_cnt <= pre_cnt + LOG2'(1);
            if (pre_cnt + LOG2'(1) == tpe) state <= ARMED;
          end
          ARMED: if (wrt_smpl && fire) begin
            triggered <= 1'b1;
            post_cnt  <= (LOG2 + 1)'(1);
            // With a maximal pre-trigger split the trigger sample alone completes the ring.
            if (post_need == (LOG2 + 1)'(1)) begin
              oldest <= wptr_nxt;
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else begin
              state <= POST;
            end
          end
          POST: if (wrt_smpl) begin
            post_cnt <= post_cnt + (LOG2 + 1)'(1);
            if (post_cnt + (LOG2 + 1)'(1) == post_need) begin
              oldest <= wptr_nxt;
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
            end
          end
          DONE: if (dump) begin
            dch    <= dump_ch;
            rd_ptr <= oldest;
            rd_cnt <= '0;
            raddr  <= oldest;
            done   <= 1'b0;
            state  <= RD;
          end
          RD: state <= LAT;
          LAT: begin
            out_data <= lane;
            out_vld  <= 1'b1;
            state    <= SEND;
          end
          SEND: if (out_rdy) begin
            out_vld <= 1'b0;
            rd_ptr  <= rd_ptr_nxt;
            rd_cnt  <= rd_cnt + LOG2'(1);
            if (rd_cnt == LAST) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              raddr <= rd_ptr_nxt;
              state <= RD;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_la_capture_engine.sv
// Bench for la_capture_engine: randomized captures and dumps scored against a
// stimulus-level model of which strobe triggers and which samples end up in the ring.
`timescale 1ns/1ps
module tb_la_capture_engine;

  localparam int NUM_CH  = 5;
  localparam int W       = 8;
  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;
  localparam int LOG2CH  = 3;
  localparam int DW      = NUM_CH * W;

  logic              clk = 1'b0;
  logic              rst, arm, abort, wrt_smpl, dump, out_rdy;
  logic [1:0]        trig_mode;
  logic [LOG2CH-1:0] trig_ch, dump_ch;
  logic [NUM_CH-1:0] trig_mask, trig_match, trig_in;
  logic [LOG2-1:0]   trig_pos, waddr, raddr;
  logic [DW-1:0]     smpl_din, wdata, rdata;
  logic              we, out_vld, busy, triggered, done;
  logic [W-1:0]      out_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  la_capture_engine #(.NUM_CH(NUM_CH), .W(W), .ENTRIES(ENTRIES), .LOG2(LOG2), .LOG2CH(LOG2CH)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trig_mode(trig_mode), .trig_ch(trig_ch),
    .trig_mask(trig_mask), .trig_match(trig_match), .trig_pos(trig_pos), .wrt_smpl(wrt_smpl),
    .smpl_din(smpl_din), .trig_in(trig_in), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata), .dump(dump), .dump_ch(dump_ch), .out_data(out_data), .out_vld(out_vld),
    .out_rdy(out_rdy), .busy(busy), .triggered(triggered), .done(done)
  );

  // Synchronous-read RAM queue shared by all lanes.
  logic [DW-1:0] mem [0:(1<<LOG2)-1];
  always @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

  logic [LOG2-1:0] wr_a[$];
  logic [DW-1:0]   wr_d[$];
  always @(negedge clk) if (we === 1'b1) begin
    wr_a.push_back(waddr);
    wr_d.push_back(wdata);
  end

  // Stimulus for the current capture: one entry per strobe after arm.
  logic [DW-1:0]     s_din[$];
  logic [NUM_CH-1:0] s_tin[$];
  int exp_trig, exp_total;

  function automatic logic [DW-1:0] rand_din();
    return {8'($urandom), $urandom};
  endfunction

  // First strobe index at or after the pre-trigger region whose trigger rule holds.
  function automatic int model_trig(input int tpe, input logic [1:0] mode, input int ch,
                                    input logic [NUM_CH-1:0] mask, input logic [NUM_CH-1:0] match);
    logic [NUM_CH-1:0] cur, prv;
    bit hit;
    for (int t = tpe; t < s_tin.size(); t++) begin
      cur = s_tin[t];
      prv = (t > 0) ? s_tin[t-1] : '0;
      hit = 0;
      case (mode)
        2'b00: if (ch < NUM_CH && t > 0) hit = !prv[ch] && cur[ch];
        2'b01: if (ch < NUM_CH && t > 0) hit = prv[ch] && !cur[ch];
        2'b10: hit = ((cur ^ match) & mask) == 0;
        default: hit = 1;
      endcase
      if (hit) return t;
    end
    return -1;
  endfunction

  task automatic run_capture(input string name, input int tp, input logic [1:0] mode, input int ch,
                             input logic [NUM_CH-1:0] mask, input logic [NUM_CH-1:0] match,
                             input int gapmax);
    int tpe, nexp, bad_f, bad_l, bad_w, ng;
    bit exp_done, exp_trd;
    tpe       = (tp > ENTRIES - 1) ? ENTRIES - 1 : tp;
    exp_trig  = model_trig(tpe, mode, ch, mask, match);
    exp_total = (exp_trig < 0) ? s_din.size() : exp_trig + ENTRIES - tpe;
    nexp      = (exp_total < s_din.size()) ? exp_total : s_din.size();
    wr_a.delete();
    wr_d.delete();
    trig_mode = mode; trig_ch = LOG2CH'(ch); trig_mask = mask; trig_match = match;
    trig_pos  = LOG2'(tp);
    arm = 1'b1; wrt_smpl = 1'($urandom_range(0, 1)); smpl_din = rand_din(); trig_in = NUM_CH'($urandom);
    @(negedge clk);
    arm = 1'b0; wrt_smpl = 1'b0;
    tests++;
    if ({busy, triggered, done, we} !== 4'b1000) begin
      fails++;
      $display("FAIL %s_arm: busy/trig/done/we=%b want 1000", name, {busy, triggered, done, we});
    end
    bad_f = 0; bad_l = 0; bad_w = 0;
    for (int i = 0; i < s_din.size(); i++) begin
      ng = $urandom_range(0, gapmax);
      repeat (ng) begin
        @(negedge clk);
        if (we !== 1'b0) bad_l++;
      end
      wrt_smpl = 1'b1; smpl_din = s_din[i]; trig_in = s_tin[i];
      @(negedge clk);
      wrt_smpl = 1'b0;
      if (i < nexp) begin
        if (we !== 1'b1 || waddr !== LOG2'(i % ENTRIES)) bad_l++;
      end else if (we !== 1'b0) bad_l++;
      exp_trd  = (exp_trig >= 0) && (i >= exp_trig);
      exp_done = (exp_trig >= 0) && (i >= exp_total - 1);
      if ({busy, triggered, done} !== {~exp_done, exp_trd, exp_done}) bad_f++;
    end
    @(negedge clk);
    tests++;
    if (bad_l != 0) begin fails++; $display("FAIL %s_write_timing: %0d bad cycles, want 0", name, bad_l); end
    tests++;
    if (bad_f != 0) begin fails++; $display("FAIL %s_flags: %0d bad cycles, want 0", name, bad_f); end
    tests++;
    if (wr_a.size() != nexp) begin
      fails++; $display("FAIL %s_write_count: got %0d want %0d", name, wr_a.size(), nexp);
    end
    for (int j = 0; j < nexp && j < wr_a.size(); j++)
      if (wr_a[j] !== LOG2'(j % ENTRIES) || wr_d[j] !== s_din[j]) bad_w++;
    tests++;
    if (bad_w != 0) begin fails++; $display("FAIL %s_write_data: %0d wrong entries, want 0", name, bad_w); end
  endtask

  task automatic run_dump(input string name, input int ch, input int rdy_pct);
    logic [W-1:0]  got[$];
    logic [W-1:0]  held, expb;
    logic [DW-1:0] d;
    int first, cyc, bad_s, bad_d;
    bit stall;
    dump = 1'b1; dump_ch = LOG2CH'(ch);
    @(negedge clk);
    dump = 1'b0;
    tests++;
    if (raddr !== LOG2'(exp_total % ENTRIES)) begin
      fails++; $display("FAIL %s_raddr0: got %0d want %0d", name, raddr, exp_total % ENTRIES);
    end
    first = -1; cyc = 1; bad_s = 0; bad_d = 0; stall = 0; held = '0;
    while (got.size() < ENTRIES && cyc < 6000) begin
      if (out_vld === 1'b1 && first < 0) first = cyc;
      if (stall && (out_vld !== 1'b1 || out_data !== held)) bad_s++;
      out_rdy = ($urandom_range(1, 100) <= rdy_pct);
      stall = (out_vld === 1'b1) && !out_rdy;
      held  = out_data;
      if (out_vld === 1'b1 && out_rdy) got.push_back(out_data);
      @(negedge clk);
      cyc++;
    end
    out_rdy = 1'b0;
    tests++;
    if (first != 3) begin fails++; $display("FAIL %s_first_vld: got cycle %0d want 3", name, first); end
    tests++;
    if (got.size() != ENTRIES) begin fails++; $display("FAIL %s_byte_count: got %0d want %0d", name, got.size(), ENTRIES); end
    for (int j = 0; j < got.size(); j++) begin
      d = s_din[exp_total - ENTRIES + j];
      expb = (ch < NUM_CH) ? d[ch*W +: W] : '0;
      if (got[j] !== expb) bad_d++;
    end
    tests++;
    if (bad_d != 0) begin fails++; $display("FAIL %s_bytes: %0d wrong bytes, want 0", name, bad_d); end
    tests++;
    if (bad_s != 0) begin fails++; $display("FAIL %s_stall_hold: %0d unstable cycles, want 0", name, bad_s); end
    tests++;
    if ({done, out_vld} !== 2'b10) begin fails++; $display("FAIL %s_end: done/out_vld=%b want 10", name, {done, out_vld}); end
  endtask

  task automatic check_idle(input string name);
    tests++;
    if ({busy, triggered, done, out_vld} !== 4'b0000) begin
      fails++; $display("FAIL %s: busy/trig/done/out_vld=%b want 0000", name, {busy, triggered, done, out_vld});
    end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({we, waddr, wdata, raddr, out_data, out_vld, busy, triggered, done} !== '0) begin
      fails++; $display("FAIL reset_outputs: got %h want 0", {we, waddr, wdata, raddr, out_data, out_vld, busy, triggered, done});
    end
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset_release");
  endtask

  task automatic test_rising();
    logic [DW-1:0] d;
    logic [NUM_CH-1:0] t;
    s_din.delete(); s_tin.delete();
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < NUM_CH; k++) d[k*W +: W] = W'(i + k);
      t = NUM_CH'($urandom);
      t[2] = (i >= 250);
      s_din.push_back(d); s_tin.push_back(t);
    end
    run_capture("rising", 100, 2'b00, 2, '0, '0, 1);
    run_dump("rising_dump", 0, 100);
  endtask

  task automatic test_force();
    s_din.delete(); s_tin.delete();
    for (int i = 0; i < 450; i++) begin s_din.push_back(rand_din()); s_tin.push_back(NUM_CH'($urandom)); end
    run_capture("force", 0, 2'b11, 0, '0, '0, 2);
    run_dump("force_dump", $urandom_range(0, NUM_CH - 1), 60);
  endtask

  task automatic test_pattern();
    logic [NUM_CH-1:0] t;
    s_din.delete(); s_tin.delete();
    for (int i = 0; i < 500; i++) begin
      t = NUM_CH'($urandom);
      if (i >= 20 && i < 30) t = 5'b11111;
      else if (i >= 30 && i < 60) t[0] = 1'b0;
      else if (i == 60) t = 5'b01101;
      s_din.push_back(rand_din()); s_tin.push_back(t);
    end
    run_capture("pattern", 20, 2'b10, 0, 5'b10001, 5'b00001, 1);
    repeat (5) @(negedge clk);
    tests++;
    if (triggered !== 1'b1) begin fails++; $display("FAIL pattern_sticky: triggered=%b want 1", triggered); end
    run_dump("pattern_dump_ch6", 6, 50);
    arm = 1'b1; trig_pos = '0; trig_mode = 2'b11;
    @(negedge clk);
    arm = 1'b0;
    tests++;
    if ({triggered, busy} !== 2'b01) begin fails++; $display("FAIL pattern_rearm: trig/busy=%b want 01", {triggered, busy}); end
    do_abort();
  endtask

  task automatic test_clamp();
    s_din.delete(); s_tin.delete();
    for (int i = 0; i < 400; i++) begin s_din.push_back(rand_din()); s_tin.push_back(NUM_CH'($urandom)); end
    run_capture("clamp", 500, 2'b11, 0, '0, '0, 0);
    run_dump("clamp_dump", 4, 100);
  endtask

  task automatic test_falling();
    int ch;
    s_din.delete(); s_tin.delete();
    for (int i = 0; i < 600; i++) begin s_din.push_back(rand_din()); s_tin.push_back(NUM_CH'($urandom)); end
    ch = $urandom_range(0, NUM_CH - 1);
    run_capture("falling", $urandom_range(1, 200), 2'b01, ch, '0, '0, 1);
    run_dump("falling_dump", ch, 70);
  endtask

  task automatic test_edge_invalid();
    s_din.delete(); s_tin.delete();
    for (int i = 0; i < 100; i++) begin s_din.push_back(rand_din()); s_tin.push_back(NUM_CH'($urandom)); end
    run_capture("edge_ch5", 0, 2'b00, 5, '0, '0, 1);
    do_abort();
  endtask

  task automatic test_abort();
    s_din.delete(); s_tin.delete();
    for (int i = 0; i < 50; i++) begin s_din.push_back(rand_din()); s_tin.push_back(NUM_CH'($urandom)); end
    run_capture("abort_post", 10, 2'b11, 0, '0, '0, 1);
    do_abort();
    check_idle("abort_post_idle");
    s_din.delete(); s_tin.delete();
    for (int i = 0; i < 5; i++) begin s_din.push_back(rand_din()); s_tin.push_back(NUM_CH'($urandom)); end
    run_capture("rearm_after_post", 0, 2'b11, 0, '0, '0, 1);
    do_abort();
    s_din.delete(); s_tin.delete();
    for (int i = 0; i < 390; i++) begin s_din.push_back(rand_din()); s_tin.push_back(NUM_CH'($urandom)); end
    run_capture("abort_send_fill", 0, 2'b11, 0, '0, '0, 0);
    out_rdy = 1'b0;
    dump = 1'b1; dump_ch = 3'd1;
    @(negedge clk);
    dump = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if (out_vld !== 1'b1) begin fails++; $display("FAIL abort_send_stalled: out_vld=%b want 1", out_vld); end
    do_abort();
    check_idle("abort_send_idle");
    s_din.delete(); s_tin.delete();
    for (int i = 0; i < 5; i++) begin s_din.push_back(rand_din()); s_tin.push_back(NUM_CH'($urandom)); end
    run_capture("rearm_after_send", 0, 2'b11, 0, '0, '0, 1);
    do_abort();
  endtask

  task automatic test_rst_armed();
    bit seen;
    s_din.delete(); s_tin.delete();
    for (int i = 0; i < 20; i++) begin s_din.push_back(rand_din()); s_tin.push_back('0); end
    run_capture("rst_armed_fill", 0, 2'b00, 1, '0, '0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({we, waddr, wdata, raddr, out_data, out_vld, busy, triggered, done} !== '0) begin
      fails++; $display("FAIL rst_armed_outputs: got %h want 0", {we, waddr, wdata, raddr, out_data, out_vld, busy, triggered, done});
    end
    out_rdy = 1'b1;
    dump = 1'b1; dump_ch = 3'd0;
    @(negedge clk);
    dump = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_vld !== 1'b0) seen = 1;
    end
    out_rdy = 1'b0;
    tests++;
    if (seen) begin fails++; $display("FAIL dump_in_idle: out_vld rose, want no out_vld"); end
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0; wrt_smpl = 1'b0; dump = 1'b0; out_rdy = 1'b0;
    trig_mode = 2'b00; trig_ch = '0; dump_ch = '0; trig_mask = '0; trig_match = '0;
    trig_in = '0; trig_pos = '0; smpl_din = '0;
    @(negedge clk);
    test_reset();
    test_rising();
    test_force();
    test_pattern();
    test_clamp();
    test_falling();
    test_edge_invalid();
    test_abort();
    test_rst_armed();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/la_capture_engine.md
# la_capture_engine

Parametrised multi-channel capture engine for the logic analyser digital core. It generalises the fixed five-channel capture path to `NUM_CH` lanes of `W` bits and `ENTRIES` depth. It adds programmable pre/post-trigger split, edge or pattern trigger, and a handshaked per-channel readout stream. It sits between the sample packers (on the `wrt_smpl` strobe) and a set of shared synchronous-read RAM queues, and feeds the command/response layer.

## Interface
- `NUM_CH`, 5, number of channels (lanes).
- `W`, 8, bits per channel per stored entry.
- `ENTRIES`, 384, queue depth; need not be a power of two.
- `LOG2`, 9, address width; must satisfy 2^LOG2 >= ENTRIES.
- `LOG2CH`, 3, channel-select width; must satisfy 2^LOG2CH >= NUM_CH.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `arm`  in  1  one-cycle pulse; starts a new capture.
- `abort`  in  1  one-cycle pulse; returns the block to IDLE.
- `trig_mode`  in  2  00 rising edge on `trig_ch`, 01 falling edge on `trig_ch`, 10 pattern match, 11 force.
- `trig_ch`  in  LOG2CH  edge-trigger channel select.
- `trig_mask`, `trig_match`  in  NUM_CH each  pattern-trigger mask and compare value.
- `trig_pos`  in  LOG2  number of pre-trigger entries.
- `wrt_smpl`  in  1  sample strobe.
- `smpl_din`  in  NUM_CH*W  packed lane data; lane k occupies bits [k*W +: W].
- `trig_in`  in  NUM_CH  per-channel trigger bits, qualified by `wrt_smpl`.
- `we`  out  1  RAM write enable.
- `waddr`  out  LOG2  RAM write address.
- `wdata`  out  NUM_CH*W  RAM write data.
- `raddr`  out  LOG2  RAM read address.
- `rdata`  in  NUM_CH*W  RAM read data, valid 1 cycle after `raddr`.
- `dump`  in  1  one-cycle pulse; read out one channel.
- `dump_ch`  in  LOG2CH  channel to dump.
- `out_data`  out  W  readout byte.
- `out_vld`  out  1  readout data valid.
- `out_rdy`  in  1  downstream ready.
- `busy`  out  1  high in PRE, ARMED and POST.
- `triggered`  out  1  sticky trigger flag.
- `done`  out  1  high in DONE.

## Operation
- States: IDLE, PRE, ARMED, POST, DONE, RD, LAT, SEND.
- **arm**, accepted in any state except RD/LAT/SEND:
  - clears `waddr`, pre count, post count, `triggered` and `prev_valid`;
  - latches trigger config, with `trig_pos_eff = min(trig_pos, ENTRIES-1)`;
  - goes to PRE, or to ARMED if `trig_pos_eff==0`.
- **abort**, in any state: goes to IDLE next cycle and clears `triggered`, `done` and `out_vld`. `abort` has priority over `arm` and `dump`.
- Every `wrt_smpl` in PRE, ARMED or POST writes `smpl_din` at `waddr`. `waddr` then increments, wrapping from ENTRIES-1 to 0.
- **PRE**: counts writes; moves to ARMED after `trig_pos_eff` writes. Triggers are not evaluated in PRE.
- **ARMED**: on each `wrt_smpl`, evaluate the trigger against the current `trig_in` and `prev` (the `trig_in` captured at the previous strobe):
  - rising: `prev_valid & ~prev[ch] & cur[ch]`;
  - falling: `prev_valid & prev[ch] & ~cur[ch]`;
  - pattern: `((cur ^ trig_match) & trig_mask) == 0`; an all-zero mask fires on the first ARMED strobe;
  - force: fires on the first ARMED strobe;
  - `trig_ch >= NUM_CH`: edge modes never fire.
- `prev` is updated on every strobe in PRE, ARMED and POST. `prev_valid` is set after the first strobe following arm.
- When the trigger fires, that sample is the first post-trigger entry: set `triggered` and go to POST.
- **POST**: writes a total of `ENTRIES - trig_pos_eff` post-trigger entries, including the trigger sample. After the last one, latch `oldest = next waddr` (the buffer is full) and go to DONE.
- **dump** in DONE:
  - latch `dump_ch`, set `rd_ptr = oldest` and `rd_cnt = 0`, go to RD;
  - `dump` outside DONE is ignored.
- **Readout loop**:
  - RD drives `raddr = rd_ptr`.
  - LAT registers lane `dump_ch` of `rdata` into `out_data` and sets `out_vld`. If `dump_ch >= NUM_CH`, `out_data` is 0.
  - SEND holds `out_data` and `out_vld` until `out_rdy`. On handshake: `out_vld` drops, `rd_ptr` increments with wrap, `rd_cnt` increments. Go back to RD, or to DONE after ENTRIES bytes.
- Repeated dumps of any channel are allowed. DONE persists until `arm`, `abort` or `rst`.

## Timing
- Reset:
  - outputs `we`, `waddr`, `wdata`, `raddr`, `out_data`, `out_vld`, `busy`, `triggered`, `done` are all 0;
  - state is IDLE.
- Write path is registered: `wrt_smpl` at cycle n gives `we=1` with `waddr`/`wdata` at n+1, for exactly one cycle.
- `busy`, `done` and `triggered` are registered and change the cycle after the causing event.
- Readout takes at least 3 cycles per byte. The first `out_vld` comes 3 cycles after `dump`, because the cycle after `dump` is the one in which RD drives `raddr`.
- `out_data` is stable while `out_vld & ~out_rdy`.
- `wrt_smpl` during RD, LAT or SEND is ignored.
- `arm` and `wrt_smpl` in the same cycle: arm wins and the sample is not written.

## Test plan
- Default params, `trig_pos=100`, rising mode, `trig_ch=2`. Counting data; `trig_in[2]` rises at strobe 250. Expect 100 PRE writes, the trigger at strobe 250, and 284 POST writes. `done` is set. Dump of ch0 returns 384 bytes starting with strobe 150's data and ending with strobe 533's.
- `trig_pos=0`, force mode. Expect exactly 384 writes starting at `waddr=0`, and the dump starts at address 0.
- Pattern mode with mask=5'b10001 and match=5'b00001. Expect no trigger on `trig_in=11111` and a trigger on `01101`; `triggered` stays high until `arm`.
- Readout with `out_rdy` toggled randomly, then `dump_ch=6`. Expect no lost or duplicated bytes, `out_data` stable while stalled, and 384 zero bytes for channel 6.
- `abort` mid-POST and mid-SEND. Expect IDLE and all flags 0 next cycle. A following `arm` starts from `waddr=0`.
- Assert `rst` during ARMED. Expect all outputs 0 next cycle. `dump` while in IDLE gives no `out_vld`.
